// File: rtl/plru_tree_updater.sv
// Per-set tree pseudo-LRU state with touch (hit) and query/claim (fill) update ports.
// Node p has children 2p+1 / 2p+2; a node bit of 1 steers the LRU search left.
module plru_tree_updater #(
  parameter int num_ways = 8,
  parameter int num_sets = 16,
  localparam int way_w = $clog2(num_ways),
  localparam int set_w = (num_sets > 1) ? $clog2(num_sets) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                touch_valid,
  input  logic [set_w-1:0]    touch_set,
  input  logic [way_w-1:0]    touch_way,
  input  logic                query_valid,
  input  logic [set_w-1:0]    query_set,
  input  logic                query_claim,
  output logic                victim_valid,
  output logic [way_w-1:0]    victim_way,
  output logic [num_ways-1:0] tree_bits
);

  logic [num_ways-1:0] tree_q [num_sets];

  logic [num_ways-1:0] query_pre;
  logic [num_ways-1:0] query_post_touch;
  logic [num_ways-1:0] claim_tree;
  logic [num_ways-1:0] touch_tree;
  logic [way_w-1:0]    query_victim;

  // Walk w's path from the root, pointing each node away from w.
  function automatic logic [num_ways-1:0] mru_update(input logic [num_ways-1:0] t,
                                                     input logic [way_w-1:0] w);
    logic [num_ways-1:0] r;
    int p;
    r = t;
    p = 0;
    for (int l = way_w - 1; l >= 0; l--) begin
      r[p] = w[l];
      p = 2 * p + 1 + int'(w[l]);
    end
    return r;
  endfunction

  function automatic logic [way_w-1:0] victim_of(input logic [num_ways-1:0] t);
    logic [way_w-1:0] v;
    logic vb;
    int p;
    v = '0;
    p = 0;
    for (int l = way_w - 1; l >= 0; l--) begin
      vb = ~t[p];
      v[l] = vb;
      p = 2 * p + 1 + int'(vb);
    end
    return v;
  endfunction

  always_comb begin
    query_pre        = tree_q[query_set];
    query_post_touch = query_pre;
    if (touch_valid && (touch_set == query_set)) begin
      query_post_touch = mru_update(query_pre, touch_way);
    end
    query_victim = victim_of(query_post_touch);
    // Built on the post-touch tree so a same-set touch and claim collapse into one write.
    claim_tree   = mru_update(query_post_touch, query_victim);
    touch_tree   = mru_update(tree_q[touch_set], touch_way);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        tree_q[s] <= '1;
      end
      victim_valid <= 1'b0;
      victim_way   <= '0;
      tree_bits    <= '1;
    end else begin
      if (touch_valid) begin
        tree_q[touch_set] <= touch_tree;
      end
      // Later assignment wins on a shared set; claim_tree already contains the touch.
      if (query_valid && query_claim) begin
        tree_q[query_set] <= claim_tree;
      end
      victim_valid <= query_valid;
      if (query_valid) begin
        victim_way <= query_victim;
        tree_bits  <= query_post_touch;
      end
    end
  end

endmodule

// File: tb/tb_plru_tree_updater.sv
// Bench for plru_tree_updater: directed test-plan steps plus random traffic against a
// history-based model (victim derived from the most recent touch under each subtree).
module tb_plru_tree_updater;

  localparam int NW = 8;
  localparam int NS = 16;
  localparam int LW = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          touch_valid;
  logic [SW-1:0] touch_set;
  logic [LW-1:0] touch_way;
  logic          query_valid;
  logic [SW-1:0] query_set;
  logic          query_claim;
  logic          victim_valid;
  logic [LW-1:0] victim_way;
  logic [NW-1:0] tree_bits;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: per-set history of ways made MRU, oldest first.
  int hist [NS][$];
  logic          exp_valid;
  logic [LW-1:0] exp_way;
  logic [NW-1:0] exp_bits;

  always #5 clk = ~clk;

  plru_tree_updater #(.num_ways(NW), .num_sets(NS)) dut (
    .clk(clk), .rst(rst),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
    .query_valid(query_valid), .query_set(query_set), .query_claim(query_claim),
    .victim_valid(victim_valid), .victim_way(victim_way), .tree_bits(tree_bits)
  );

  // Most recent way in set s whose top d address bits equal pre; -1 if none.
  function automatic int last_under(int s, int d, int pre);
    for (int i = hist[s].size() - 1; i >= 0; i--) begin
      if ((hist[s][i] >> (LW - d)) == pre) return hist[s][i];
    end
    return -1;
  endfunction

  // Untouched subtree keeps its reset orientation (LRU on the left, i.e. bit 0).
  function automatic int model_victim(int s);
    int pre = 0;
    for (int d = 0; d < LW; d++) begin
      int w = last_under(s, d, pre);
      int b = (w < 0) ? 0 : (1 - ((w >> (LW - 1 - d)) & 1));
      pre = pre * 2 + b;
    end
    return pre;
  endfunction

  function automatic logic [NW-1:0] model_tree(int s);
    logic [NW-1:0] t = '1;
    for (int d = 0; d < LW; d++) begin
      for (int pre = 0; pre < (1 << d); pre++) begin
        int w = last_under(s, d, pre);
        if (w >= 0) t[(1 << d) - 1 + pre] = 1'((w >> (LW - 1 - d)) & 1);
      end
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance model, check registered outputs after the edge.
  task automatic cyc(input logic r, input logic tv, input int ts, input int tw,
                     input logic qv, input int qs, input logic qc);
    rst = r; touch_valid = tv; touch_set = SW'(ts); touch_way = LW'(tw);
    query_valid = qv; query_set = SW'(qs); query_claim = qc;
    if (r) begin
      for (int s = 0; s < NS; s++) hist[s].delete();
      exp_valid = 1'b0; exp_way = '0; exp_bits = '1;
    end else begin
      if (tv) hist[ts].push_back(tw);
      exp_valid = qv;
      if (qv) begin
        int v = model_victim(qs);
        exp_way  = LW'(v);
        exp_bits = model_tree(qs);
        if (qc) hist[qs].push_back(v);
      end
    end
    @(posedge clk);
    #1;
    chk("victim_valid", 32'(victim_valid), 32'(exp_valid));
    chk("victim_way", 32'(victim_way), 32'(exp_way));
    chk("tree_bits", 32'(tree_bits), 32'(exp_bits));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic query(input int s, input logic c);
    cyc(1'b0, 1'b0, 0, 0, 1'b1, s, c);
  endtask

  task automatic touch(input int s, input int w);
    cyc(1'b0, 1'b1, s, w, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int claim_seq [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

    rst = 1'b1; touch_valid = 1'b0; touch_set = '0; touch_way = '0;
    query_valid = 1'b0; query_set = '0; query_claim = 1'b0;
    exp_valid = 1'b0; exp_way = '0; exp_bits = '1;

    cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    chk("reset_valid", 32'(victim_valid), 32'd0);
    chk("reset_bits", 32'(tree_bits), 32'hFF);

    query(3, 1'b0);
    chk("q3_way", 32'(victim_way), 32'd0);
    chk("q3_valid", 32'(victim_valid), 32'd1);
    idle();
    chk("q3_drop", 32'(victim_valid), 32'd0);

    touch(3, 0);
    query(3, 1'b0);
    chk("t3w0_victim", 32'(victim_way), 32'd4);
    touch(3, 4);
    query(3, 1'b0);
    chk("t3w4_victim", 32'(victim_way), 32'd2);
    query(0, 1'b0);
    chk("other_set", 32'(victim_way), 32'd0);

    for (int i = 0; i < 9; i++) begin
      query(5, 1'b1);
      chk($sformatf("claim5_%0d", i), 32'(victim_way), 32'(claim_seq[i]));
    end

    // Touch on another set must not affect the query.
    cyc(1'b0, 1'b1, 2, 0, 1'b1, 1, 1'b0);
    chk("diffset_victim", 32'(victim_way), 32'd0);
    cyc(1'b0, 1'b1, 1, 0, 1'b1, 1, 1'b0);
    chk("sameset_victim", 32'(victim_way), 32'd4);

    // Fresh set: touch way 4 leaves the left subtree untouched, so victim 0, then 6.
    cyc(1'b0, 1'b1, 6, 4, 1'b1, 6, 1'b1);
    chk("touch_claim6", 32'(victim_way), 32'd0);
    chk("touch_claim6_bits", 32'(tree_bits), 32'hDB);
    query(6, 1'b0);
    chk("after_claim6", 32'(victim_way), 32'd6);

    touch(0, 5);
    cyc(1'b0, 1'b1, 7, 2, 1'b1, 0, 1'b1);
    query(7, 1'b1);
    cyc(1'b1, 1'b1, 0, 3, 1'b1, 7, 1'b1);
    chk("rst_mid_valid", 32'(victim_valid), 32'd0);
    idle();
    chk("post_rst_valid", 32'(victim_valid), 32'd0);
    for (int s = 0; s < NS; s += 5) begin
      query(s, 1'b0);
      chk($sformatf("post_rst_way_%0d", s), 32'(victim_way), 32'd0);
      chk($sformatf("post_rst_bits_%0d", s), 32'(tree_bits), 32'hFF);
    end

    // Random traffic on a few sets so touches and claims collide often.
    for (int i = 0; i < 600; i++) begin
      logic r  = ($urandom_range(0, 59) == 0);
      logic tv = 1'($urandom_range(0, 1));
      logic qv = ($urandom_range(0, 3) != 0);
      logic qc = 1'($urandom_range(0, 1));
      int   ts = $urandom_range(0, 3);
      int   qs = $urandom_range(0, 3);
      int   tw = $urandom_range(0, NW - 1);
      cyc(r, tv, ts, tw, qv, qs, qc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
